replica_exchange_sched: RTL

- Parametrised successor to the fixed two-sub-node (or-opt / two-opt) replica exchange inside a node.
- Serves NCH optimisation channels in one node.
- Per request it runs a replica exchange test on adjacent channel pairs and alternates even/odd pairing.
- For each accepted pair it streams the city ordering between the two channels' ordering memories and swaps their total distances.
- Sits between the per-channel sub_node distance/ordering storage and the node-level control.

---
 rtl/replica_pkg.sv | 30 +++
 rtl/replica_exchange_sched_if.sv | 45 ++++
 rtl/replica_exchange_sched_exchange_test.sv | 30 +++
 rtl/replica_exchange_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/replica_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : replica_pkg
//  Description : Shared types for the replica exchange scheduler: FSM state
//                encoding, city address type and an address-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package replica_pkg;

    // Default ordering length used to size city_addr_t.
    localparam int DEF_CITY_NUM = 16;

    // Address width for a memory of n entries (never less than 1 bit).
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CITY_AW = addr_width(DEF_CITY_NUM);

    typedef logic [CITY_AW-1:0] city_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } ex_state_t;

endpackage
`default_nettype wire

// File: rtl/replica_exchange_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : replica_exchange_sched_if
//  Description : Bus between node control / per-channel storage and the
//                replica exchange scheduler.
//  Ports       : master = control + storage side (drives start, threshold,
//                distances and ordering read data); slave = scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface replica_exchange_sched_if #(
    parameter int NCH      = 2,
    parameter int CITY_NUM = 16,
    parameter int CITY_W   = 8,
    parameter int DIS_W    = 32
);
    localparam int AW = replica_pkg::addr_width(CITY_NUM);

    logic                    start;
    logic [DIS_W-1:0]        accept_thr;
    logic [NCH*DIS_W-1:0]    dis_data;
    logic [AW-1:0]           ord_raddr;
    logic [NCH*CITY_W-1:0]   ord_rdata;
    logic [NCH-1:0]          ord_we;
    logic [AW-1:0]           ord_waddr;
    logic [NCH*CITY_W-1:0]   ord_wdata;
    logic [NCH-1:0]          dis_we;
    logic [NCH*DIS_W-1:0]    dis_wdata;
    logic [NCH-2:0]          accepted;
    logic                    busy;
    logic                    done;

    modport master (
        output start, accept_thr, dis_data, ord_rdata,
        input  ord_raddr, ord_we, ord_waddr, ord_wdata,
        input  dis_we, dis_wdata, accepted, busy, done
    );

    modport slave (
        input  start, accept_thr, dis_data, ord_rdata,
        output ord_raddr, ord_we, ord_waddr, ord_wdata,
        output dis_we, dis_wdata, accepted, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/replica_exchange_sched_exchange_test.sv
`default_nettype none
// ============================================================================
//  Module      : exchange_test
//  Description : Acceptance test for one adjacent channel pair (lo, hi).
//                delta = dis_hi - dis_lo as a signed DIS_W+1 value; the pair
//                is accepted when enabled and delta <= 0 or delta < thr.
//  Ports       : en (pair active this phase), dis_lo, dis_hi, thr -> accept
//  Revision    : 1.0 - initial release
// ============================================================================
module exchange_test #(
    parameter int DIS_W = 32
) (
    input  wire logic             en,
    input  wire logic [DIS_W-1:0] dis_lo,
    input  wire logic [DIS_W-1:0] dis_hi,
    input  wire logic [DIS_W-1:0] thr,
    output logic                  accept
);
    logic signed [DIS_W:0] w_delta;
    logic signed [DIS_W:0] w_thr;
    logic                  w_non_pos;

    assign w_delta   = $signed({1'b0, dis_hi}) - $signed({1'b0, dis_lo});
    assign w_thr     = $signed({1'b0, thr});
    // Sign bit set or all zero means the exchange does not worsen the tour.
    assign w_non_pos = w_delta[DIS_W] || (w_delta == '0);
    assign accept    = en && (w_non_pos || (w_delta < w_thr));

endmodule
`default_nettype wire

// File: rtl/replica_exchange_sched.sv
`default_nettype none
// ============================================================================
//  Module      : replica_exchange_sched
//  Description : Replica exchange between NCH optimisation channels. Each
//                round tests adjacent pairs of one parity (even/odd
//                alternating), then streams the city ordering between the
//                channels of every accepted pair and swaps their distances.
//  Ports       : clk, reset (async, active high),
//                bus (slave modport): start/accept_thr/dis_data in,
//                ordering read/write ports, distance write port,
//                accepted mask, busy, done.
//  Revision    : 1.0 - initial release
// ============================================================================
module replica_exchange_sched
    import replica_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CITY_NUM = 16,
    parameter int CITY_W   = 8,
    parameter int DIS_W    = 32
) (
    input  wire logic               clk,
    input  wire logic               reset,
    replica_exchange_sched_if.slave bus
);
    localparam int AW = addr_width(CITY_NUM);
    localparam int CW = addr_width(CITY_NUM + 1);
    localparam logic [CW-1:0] c_last_cnt = CW'(CITY_NUM);
    localparam logic [CW-1:0] c_last_rd  = CW'(CITY_NUM - 1);

    ex_state_t              r_state;
    logic                   r_phase;
    logic [NCH-2:0]         r_accepted;
    logic [NCH-1:0]         r_ch_mask;
    logic [NCH-1:0]         r_hi;
    logic [NCH-1:0]         r_ord_we;
    logic [NCH-1:0]         r_dis_we;
    logic [NCH*DIS_W-1:0]   r_dis_wdata;
    logic [AW-1:0]          r_raddr;
    logic [AW-1:0]          r_waddr;
    logic [CW-1:0]          r_cnt;
    logic                   r_busy;
    logic                   r_done;

    logic [NCH-2:0]             w_pair_mask;
    logic [NCH-1:0]             w_lo;
    logic [NCH-1:0]             w_hi;
    logic [NCH-1:0]             w_ch_mask;
    logic [(NCH+2)*DIS_W-1:0]   w_dis_pad;
    logic [(NCH+2)*CITY_W-1:0]  w_rd_pad;
    logic [NCH*DIS_W-1:0]       w_dis_swap;
    logic [NCH*CITY_W-1:0]      w_ord_wdata;

    // One acceptance test per adjacent pair; only pairs whose low index
    // matches the current phase parity are enabled.
    for (genvar i = 0; i < NCH - 1; i++) begin : g_pair
        localparam logic c_par = logic'(i % 2);
        exchange_test #(.DIS_W(DIS_W)) u_test (
            .en     (r_phase == c_par),
            .dis_lo (bus.dis_data[i*DIS_W +: DIS_W]),
            .dis_hi (bus.dis_data[(i+1)*DIS_W +: DIS_W]),
            .thr    (bus.accept_thr),
            .accept (w_pair_mask[i])
        );
    end

    // Channel k is the low member of pair k or the high member of pair k-1.
    // Same-parity pairs never overlap, so at most one of these is set.
    assign w_lo      = {1'b0, w_pair_mask};
    assign w_hi      = {w_pair_mask, 1'b0};
    assign w_ch_mask = w_lo | w_hi;

    // Zero slots on both ends so that channel k sits at slot k+1 and both
    // neighbours (slots k and k+2) are always in range.
    assign w_dis_pad = {{DIS_W{1'b0}},  bus.dis_data,  {DIS_W{1'b0}}};
    assign w_rd_pad  = {{CITY_W{1'b0}}, bus.ord_rdata, {CITY_W{1'b0}}};

    always_comb begin
        w_dis_swap = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_hi[k]) begin
                w_dis_swap[k*DIS_W +: DIS_W] = w_dis_pad[k*DIS_W +: DIS_W];
            end else if (w_lo[k]) begin
                w_dis_swap[k*DIS_W +: DIS_W] = w_dis_pad[(k+2)*DIS_W +: DIS_W];
            end
        end
    end

    // Write data is the partner's read data, which arrives the cycle the
    // write is issued, so this path stays combinational and is gated by the
    // registered enable.
    always_comb begin
        w_ord_wdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_ord_we[k]) begin
                if (r_hi[k]) begin
                    w_ord_wdata[k*CITY_W +: CITY_W] = w_rd_pad[k*CITY_W +: CITY_W];
                end else begin
                    w_ord_wdata[k*CITY_W +: CITY_W] = w_rd_pad[(k+2)*CITY_W +: CITY_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase     <= 1'b0;
            r_accepted  <= '0;
            r_ch_mask   <= '0;
            r_hi        <= '0;
            r_ord_we    <= '0;
            r_dis_we    <= '0;
            r_dis_wdata <= '0;
            r_raddr     <= '0;
            r_waddr     <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= TEST;
                        r_busy  <= 1'b1;
                    end
                end

                TEST: begin
                    r_accepted <= w_pair_mask;
                    r_ch_mask  <= w_ch_mask;
                    r_hi       <= w_hi;
                    r_raddr    <= '0;
                    r_waddr    <= '0;
                    r_cnt      <= '0;
                    if (|w_pair_mask) begin
                        r_state     <= SWAP;
                        r_dis_we    <= w_ch_mask;
                        r_dis_wdata <= w_dis_swap;
                    end else begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                // r_cnt = 0 issues only the first read; every later count
                // writes the address read one cycle earlier.
                SWAP: begin
                    r_dis_we    <= '0;
                    r_dis_wdata <= '0;
                    if (r_cnt == c_last_cnt) begin
                        r_ord_we <= '0;
                        r_raddr  <= '0;
                        r_waddr  <= '0;
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_ord_we <= r_ch_mask;
                        r_waddr  <= r_raddr;
                        if (r_cnt != c_last_rd) begin
                            r_raddr <= r_raddr + 1'b1;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_phase <= ~r_phase;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ord_raddr = r_raddr;
    assign bus.ord_we    = r_ord_we;
    assign bus.ord_waddr = r_waddr;
    assign bus.ord_wdata = w_ord_wdata;
    assign bus.dis_we    = r_dis_we;
    assign bus.dis_wdata = r_dis_wdata;
    assign bus.accepted  = r_accepted;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire
